// File: rtl/hack_seq_pkg.sv
// Shared definitions for the Hack CPU run-control sequencer.
//   state_e    : sequencer states
//   OP_*       : host command opcodes carried on cmd_op_i
//   ADDR_W_DEF : default instruction ROM / PC address width
package hack_seq_pkg;

  localparam int ADDR_W_DEF = 15;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_HALT = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_STEP = 3'd4
  } state_e;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

endpackage

// File: rtl/hack_seq_loader.sv
// Program loader: streams host words into the instruction ROM write port.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   start_i              : clear pointer, word count and overflow flag
//   active_i             : sequencer is in the load state
//   ld_valid_i/ld_data_i/ld_last_i/ld_ready_o : program word stream
//   rom_we_o/rom_addr_o/rom_wdata_o           : ROM write port
//   done_o               : accepted word ends the load (last or ROM full)
//   err_ovf_o            : sticky, ROM filled without a last word
//   words_loaded_o       : words written by the current/last load
module hack_seq_loader
  import hack_seq_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ROM_DEPTH = 32768
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              active_i,
  input  logic              ld_valid_i,
  input  logic [15:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [15:0]       rom_wdata_o,
  output logic              done_o,
  output logic              err_ovf_o,
  output logic [15:0]       words_loaded_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [15:0]       words_q;
  logic              err_ovf_q;
  logic              xfer;
  logic              at_end;

  assign xfer   = active_i && ld_valid_i;
  assign at_end = (wr_ptr_q == LAST_ADDR);
  assign done_o = xfer && (ld_last_i || at_end);

  assign ld_ready_o     = active_i;
  assign rom_we_o       = xfer;
  assign rom_addr_o     = wr_ptr_q;
  assign rom_wdata_o    = ld_data_i;
  assign err_ovf_o      = err_ovf_q;
  assign words_loaded_o = words_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      words_q   <= '0;
      err_ovf_q <= 1'b0;
    end else if (start_i) begin
      wr_ptr_q  <= '0;
      words_q   <= '0;
      err_ovf_q <= 1'b0;
    end else if (xfer) begin
      // at a full ROM the pointer wraps, harmless since the load ends here
      wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      words_q  <= words_q + 16'd1;
      if (at_end && !ld_last_i) begin
        err_ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hack_cpu_sequencer.sv
// Hack CPU run-control: holds the CPU in reset while a program is loaded,
// then gates execution via cpu_en_o with run / halt / single-step and a
// PC breakpoint.
// Ports:
//   clk_i, rst_ni                     : clock, async active-low reset
//   cmd_valid_i/cmd_op_i/cmd_ready_o  : host command handshake
//   ld_*                              : program word stream
//   rom_we_o/rom_addr_o/rom_wdata_o   : instruction ROM write port
//   pc_i, bp_en_i, bp_addr_i          : CPU PC and breakpoint setup
//   cpu_reset_o, cpu_en_o             : CPU reset and clock enable
//   halted_o, loading_o, err_ovf_o, words_loaded_o, run_cycles_o : status
module hack_cpu_sequencer
  import hack_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int ROM_DEPTH  = 32768,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  input  logic [1:0]        cmd_op_i,
  output logic              cmd_ready_o,
  input  logic              ld_valid_i,
  input  logic [15:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [15:0]       rom_wdata_o,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              bp_en_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  output logic              cpu_reset_o,
  output logic              cpu_en_o,
  output logic              halted_o,
  output logic              loading_o,
  output logic              err_ovf_o,
  output logic [15:0]       words_loaded_o,
  output logic [31:0]       run_cycles_o
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  rst_cnt_q;
  logic              bp_skip_q;
  logic [31:0]       run_cycles_q;

  logic cmd_fire;
  logic load_start;
  logic bp_hit;
  logic run_tick;
  logic ld_done;

  assign cmd_ready_o = (state_q == S_HALT) || (state_q == S_RUN);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign load_start  = cmd_fire && (cmd_op_i == OP_LOAD);

  // bp_skip lets RUN resume from a PC that is sitting on the breakpoint
  assign bp_hit   = (state_q == S_RUN) && bp_en_i && (pc_i == bp_addr_i) && !bp_skip_q;
  assign run_tick = ((state_q == S_RUN) && !bp_hit) || (state_q == S_STEP);

  // cpu_en is high in reset so the CPU's synchronous reset is clocked in
  assign cpu_en_o     = (state_q == S_RST) || run_tick;
  assign cpu_reset_o  = (state_q == S_RST) || (state_q == S_LOAD);
  assign halted_o     = (state_q == S_HALT);
  assign loading_o    = (state_q == S_LOAD);
  assign run_cycles_o = run_cycles_q;

  hack_seq_loader #(
    .ADDR_W   (ADDR_W),
    .ROM_DEPTH(ROM_DEPTH)
  ) u_loader (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (load_start),
    .active_i      (state_q == S_LOAD),
    .ld_valid_i    (ld_valid_i),
    .ld_data_i     (ld_data_i),
    .ld_last_i     (ld_last_i),
    .ld_ready_o    (ld_ready_o),
    .rom_we_o      (rom_we_o),
    .rom_addr_o    (rom_addr_o),
    .rom_wdata_o   (rom_wdata_o),
    .done_o        (ld_done),
    .err_ovf_o     (err_ovf_o),
    .words_loaded_o(words_loaded_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_RST;
      rst_cnt_q    <= '0;
      bp_skip_q    <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      if (run_tick && (run_cycles_q != '1)) begin
        run_cycles_q <= run_cycles_q + 32'd1;
      end
      // a LOAD clear below is assigned later, so it overrides the increment
      case (state_q)
        S_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q   <= S_HALT;
            rst_cnt_q <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + CNT_W'(1);
          end
        end
        S_HALT: begin
          if (cmd_fire) begin
            case (cmd_op_i)
              OP_LOAD: begin
                state_q      <= S_LOAD;
                run_cycles_q <= '0;
              end
              OP_RUN: begin
                state_q   <= S_RUN;
                bp_skip_q <= 1'b1;
              end
              OP_STEP: state_q <= S_STEP;
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (ld_done) begin
            state_q <= S_RST;
          end
        end
        S_RUN: begin
          bp_skip_q <= 1'b0;
          if (load_start) begin
            state_q      <= S_LOAD;
            run_cycles_q <= '0;
          end else if (bp_hit || (cmd_fire && (cmd_op_i == OP_HALT))) begin
            state_q <= S_HALT;
          end
        end
        S_STEP: state_q <= S_HALT;
        default: state_q <= S_RST;
      endcase
    end
  end

endmodule

// File: doc/hack_cpu_sequencer.md
Name: hack_cpu_sequencer

Overview:
Run-control block for the Hack CPU. It holds the CPU in reset while a program is streamed into instruction ROM, then releases it. It gates CPU execution through a clock enable with run/halt/single-step commands and a PC breakpoint. It sits between the host/debug interface and the CPU + instruction ROM write port, and is the only block that drives CPU reset and CPU clock enable.

Parameters:
ADDR_W, 15, instruction ROM / PC address width
ROM_DEPTH, 32768, instruction ROM words; must be <= 2**ADDR_W
RST_CYCLES, 2, cycles cpu_reset is held after load or power-up (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command strobe
cmd_op  in  2  00 LOAD, 01 RUN, 10 HALT, 11 STEP
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
ld_valid  in  1  program word valid
ld_data  in  16  program word
ld_last  in  1  final word of program
ld_ready  out  1  sequencer accepts word
rom_we  out  1  instruction ROM write enable
rom_addr  out  ADDR_W  ROM write address
rom_wdata  out  16  ROM write data
pc  in  ADDR_W  CPU program counter
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_W  breakpoint PC
cpu_reset  out  1  to CPU reset (active-high, synchronous in CPU)
cpu_en  out  1  CPU clock enable
halted  out  1  state == S_HALT
loading  out  1  state == S_LOAD
err_ovf  out  1  sticky: load hit ROM_DEPTH without ld_last
words_loaded  out  16  words written by last load
run_cycles  out  32  enabled CPU cycles since last load

Behaviour:
- States: S_RST, S_HALT, S_LOAD, S_RUN, S_STEP. Encoding goes in the package.
- Async reset (reset==0): state=S_RST, rst_cnt=0, wr_ptr=0, words_loaded=0, run_cycles=0, err_ovf=0, bp_skip=0. ROM contents are untouched.
- S_RST: cpu_reset=1, cpu_en=1 (lets the CPU PC reset take effect). After RST_CYCLES cycles go to S_HALT, rst_cnt=0.
- S_HALT: cpu_reset=0, cpu_en=0, cmd_ready=1.
  - LOAD: go to S_LOAD, wr_ptr=0, words_loaded=0, run_cycles=0, err_ovf=0.
  - RUN: go to S_RUN, bp_skip=1.
  - STEP: go to S_STEP.
  - HALT: ignored.
- S_LOAD: cpu_reset=1, cpu_en=0, cmd_ready=0, ld_ready=1.
  - rom_we = ld_valid (combinational). rom_addr=wr_ptr, rom_wdata=ld_data.
  - On each transfer: wr_ptr++, words_loaded++.
  - Transfer with ld_last: go to S_RST.
  - Transfer at wr_ptr==ROM_DEPTH-1 without ld_last: err_ovf=1, go to S_RST. Later words wait for the next LOAD.
- S_RUN: cmd_ready=1, cpu_reset=0.
  - bp_hit = bp_en && pc==bp_addr && !bp_skip.
  - cpu_en = !bp_hit (combinational), so the instruction at bp_addr is not executed.
  - bp_skip clears after the first S_RUN cycle.
  - bp_hit or HALT: go to S_HALT; cpu_en=0 from the next cycle (bp: same cycle).
  - LOAD: go to S_LOAD (same clears as from S_HALT). LOAD wins over a simultaneous bp_hit.
  - RUN, STEP: ignored.
- S_STEP: cpu_en=1 for exactly one cycle, breakpoint ignored, cmd_ready=0, then S_HALT.
- Outputs outside their states: rom_we=0, ld_ready=0. Outputs after reset: cmd_ready=0, cpu_reset=1, cpu_en=1 (S_RST).
- run_cycles increments on every cycle with cpu_en=1 in S_RUN or S_STEP, and saturates at 2**32-1.
- words_loaded is 16 bits so the value 32768 is representable.

Decomposition:
- Package hack_seq_pkg holds:
  - state enum (S_RST..S_STEP)
  - cmd_op constants (OP_LOAD/OP_RUN/OP_HALT/OP_STEP)
  - ADDR_W default
- One natural sub-module: hack_seq_loader (wr_ptr, words_loaded, overflow detection, ROM write-port drive) instantiated by the FSM top.

Test Plan:
- Reset release -> cpu_reset=1, cpu_en=1 for 2 cycles; then halted=1, cpu_en=0, cmd_ready=1.
- LOAD, 3 words 0x0002/0xEC10/0x0000 (last on 3rd) -> rom_we at addr 0,1,2 with those data; words_loaded=3; 2-cycle cpu_reset; halted=1.
- RUN with bp_en=1, bp_addr=5; CPU counts pc 0..5 -> cpu_en low in the pc==5 cycle; halted=1; run_cycles=5. RUN again -> pc 5 executes (bp_skip).
- STEP from halt -> exactly one cpu_en pulse, run_cycles+1, halted=1 next cycle; STEP at bp_addr still executes.
- ROM_DEPTH=4, 5 words without ld_last -> 4 writes, err_ovf=1, ld_ready=0 after 4th, S_RST then S_HALT.
- Assert reset mid-load after 2 words -> immediately cpu_reset=1, rom_we=0, words_loaded=0, err_ovf=0; S_RST sequence on release.
